// File: rtl/can_bit_rx.sv
// can_bit_rx: receive-side CAN bit timing and destuffing.
//
// Synchronises the raw bus line, recovers bit timing (hard sync on SOF,
// SJW-limited resync inside a frame), samples each bit at the end of PBS1,
// strips stuff bits and hands one destuffed bit per strobe to the frame
// decoder. Bit layout is SS | PS | PBS1 | PBS2 with 1 TQ = 1 clk.
//
// Ports:
//   clk        single clock, one TQ per cycle
//   rst        asynchronous active-low reset
//   can_rx     raw bus line (0 dominant, 1 recessive), asynchronous to clk
//   destuff_en high from SOF through the CRC field (from frame decoder)
//   bit_out    destuffed sampled bit, valid while bit_val is high
//   bit_val    one-clock strobe per delivered bit
//   sof        one-clock strobe with bit_val for the SOF bit
//   stuff_err  one-clock strobe on a stuff violation
//   bus_idle   level, high while the receiver is in IDLE
module can_bit_rx #(
  parameter int PS   = 8,
  parameter int PBS1 = 8,
  parameter int PBS2 = 8,
  parameter int SJW  = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic can_rx,
  input  logic destuff_en,
  output logic bit_out,
  output logic bit_val,
  output logic sof,
  output logic stuff_err,
  output logic bus_idle
);

  localparam int N  = 1 + PS + PBS1 + PBS2;
  // Counter must reach the nominal end plus the largest late-edge extension.
  localparam int CW = $clog2(N + SJW + 1);

  localparam logic [CW-1:0] ZERO_C = CW'(0);
  localparam logic [CW-1:0] ONE_C  = CW'(1);
  localparam logic [CW-1:0] SP_C   = CW'(PS + PBS1);
  localparam logic [CW-1:0] END_C  = CW'(N - 1);
  localparam logic [CW-1:0] N_C    = CW'(N);
  localparam logic [CW-1:0] SJW_C  = CW'(SJW);

  typedef enum logic [1:0] {
    ST_INTEGRATE = 2'd0,
    ST_IDLE      = 2'd1,
    ST_FRAME     = 2'd2
  } state_t;

  logic          sync_r;
  logic          rx_s;
  logic          rx_prev;
  state_t        state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] sp_r;         // sample point of the current bit
  logic [CW-1:0] end_r;        // last count of the current bit
  logic          hs_bit;       // current bit began with a hard sync
  logic          resync_done;  // this bit has already been resynchronised
  logic          last_smp;
  logic [2:0]    run_cnt;
  logic          run_val;
  logic [3:0]    rec_cnt;      // recessive-sample counter (integration / EOF)

  logic          fall;
  logic          resync_ok;
  logic [CW-1:0] late_jump;
  logic [CW-1:0] early_dist;
  logic [CW-1:0] early_jump;
  logic [CW-1:0] early_end;
  logic          late_edge;
  logic          early_edge;
  logic          early_restart;
  logic          bit_done;
  logic          sample_now;

  // Two-flop synchroniser plus previous-value flop for edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_r  <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      sync_r  <= can_rx;
      rx_s    <= sync_r;
      rx_prev <= rx_s;
    end
  end

  // Resync decision and bit-boundary detection for the current cycle.
  always_comb begin
    fall       = rx_prev & ~rx_s;
    // Edges count only after a recessive sample, once per bit, never in the
    // hard-synced bit, and never exactly at SS.
    resync_ok  = (state == ST_FRAME) && fall && last_smp && !hs_bit &&
                 !resync_done && (cnt != ZERO_C);
    late_jump  = (cnt < SJW_C) ? cnt : SJW_C;
    early_dist = N_C - cnt;
    early_jump = (early_dist < SJW_C) ? early_dist : SJW_C;
    early_end  = END_C - early_jump;
    late_edge  = resync_ok && (cnt <= SP_C);
    early_edge = resync_ok && (cnt > SP_C);
    // Shortened end already behind us: this edge cycle becomes SS of a new bit.
    early_restart = early_edge && (cnt > early_end);
    if (early_restart || late_edge) begin
      bit_done = 1'b0;
    end else if (early_edge) begin
      bit_done = (cnt == early_end);
    end else begin
      bit_done = (cnt >= end_r);
    end
    // A late edge on the sample cycle itself pushes the sample point out.
    sample_now = (cnt == sp_r) && !late_edge;
  end

  // Receiver FSM: integration, idle/hard sync, framed sampling and destuffing.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_INTEGRATE;
      cnt         <= ZERO_C;
      sp_r        <= SP_C;
      end_r       <= END_C;
      hs_bit      <= 1'b0;
      resync_done <= 1'b0;
      last_smp    <= 1'b1;
      run_cnt     <= 3'd0;
      run_val     <= 1'b1;
      rec_cnt     <= 4'd0;
      bit_out     <= 1'b1;
      bit_val     <= 1'b0;
      sof         <= 1'b0;
      stuff_err   <= 1'b0;
      bus_idle    <= 1'b0;
    end else begin
      bit_val   <= 1'b0;
      sof       <= 1'b0;
      stuff_err <= 1'b0;
      case (state)
        ST_INTEGRATE: begin
          bus_idle <= 1'b0;
          cnt      <= (cnt >= END_C) ? ZERO_C : cnt + ONE_C;
          if (cnt == SP_C) begin
            if (rx_s) begin
              if (rec_cnt == 4'd10) begin
                state    <= ST_IDLE;
                bus_idle <= 1'b1;
                rec_cnt  <= 4'd0;
              end else begin
                rec_cnt <= rec_cnt + 4'd1;
              end
            end else begin
              rec_cnt <= 4'd0;
            end
          end
        end

        ST_IDLE: begin
          bus_idle <= 1'b1;
          if (fall) begin
            // The edge cycle itself is SS (cnt = 0), so count on from 1.
            state       <= ST_FRAME;
            bus_idle    <= 1'b0;
            cnt         <= ONE_C;
            sp_r        <= SP_C;
            end_r       <= END_C;
            hs_bit      <= 1'b1;
            resync_done <= 1'b0;
            run_cnt     <= 3'd0;
            rec_cnt     <= 4'd0;
          end else begin
            cnt <= ZERO_C;
          end
        end

        ST_FRAME: begin
          bus_idle <= 1'b0;
          if (early_restart) begin
            cnt         <= ONE_C;
            sp_r        <= SP_C;
            end_r       <= END_C;
            hs_bit      <= 1'b0;
            resync_done <= 1'b0;
          end else if (bit_done) begin
            cnt         <= ZERO_C;
            sp_r        <= SP_C;
            end_r       <= END_C;
            hs_bit      <= 1'b0;
            resync_done <= 1'b0;
          end else begin
            cnt <= cnt + ONE_C;
            if (late_edge) begin
              sp_r        <= SP_C + late_jump;
              end_r       <= END_C + late_jump;
              resync_done <= 1'b1;
            end else if (early_edge) begin
              end_r       <= early_end;
              resync_done <= 1'b1;
            end
          end

          if (sample_now) begin
            last_smp <= rx_s;
            if (hs_bit && rx_s) begin
              // Recessive first sample: the falling edge was a glitch.
              state    <= ST_IDLE;
              bus_idle <= 1'b1;
            end else if (destuff_en && (run_cnt == 3'd5)) begin
              if (rx_s != run_val) begin
                run_cnt <= 3'd1;
                run_val <= rx_s;
              end else begin
                stuff_err <= 1'b1;
                state     <= ST_INTEGRATE;
                rec_cnt   <= 4'd0;
              end
            end else begin
              bit_val <= 1'b1;
              bit_out <= rx_s;
              sof     <= hs_bit;
              if (destuff_en) begin
                rec_cnt <= 4'd0;
                if ((run_cnt != 3'd0) && (rx_s == run_val)) begin
                  run_cnt <= run_cnt + 3'd1;
                end else begin
                  run_cnt <= 3'd1;
                  run_val <= rx_s;
                end
              end else begin
                run_cnt <= 3'd0;
                if (rx_s) begin
                  if (rec_cnt == 4'd10) begin
                    state    <= ST_IDLE;
                    bus_idle <= 1'b1;
                    rec_cnt  <= 4'd0;
                  end else begin
                    rec_cnt <= rec_cnt + 4'd1;
                  end
                end else begin
                  rec_cnt <= 4'd0;
                end
              end
            end
          end
        end

        default: begin
          state    <= ST_INTEGRATE;
          cnt      <= ZERO_C;
          rec_cnt  <= 4'd0;
          bus_idle <= 1'b0;
        end
      endcase
    end
  end

endmodule
